csr_file: RTL

- Machine-mode CSR register file and trap unit for the RV32I 3-stage pipeline.
- Sits in the execute/writeback stage, downstream of the decode controller.
- Consumes the controller's csr_reg_wr, csr_reg_rd and funct3, and returns read data for writeback select 2'b11.
- Takes timer and external interrupts, and drives a PC redirect for trap entry and mret.

---
 rtl/csr_file.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit for the RV32I 3-stage pipeline (execute/writeback stage).
// Define CSR_VECTORED_EN to make mtvec.MODE writable and enable vectored interrupt entry.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          HART_ID     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        csr_reg_wr,
    input  logic        csr_reg_rd,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] pc,
    input  logic        is_mret,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic [29:0] r_mtvec_base;
    logic [31:0] r_mscratch;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mip_mtip;
    logic        r_mip_meip;
    logic [63:0] r_mcycle;

    logic [1:0]  w_mtvec_mode;
    logic [31:0] w_old;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_do_op;
    logic        w_wr;
    logic        w_ext_pend;
    logic        w_tmr_pend;
    logic        w_irq_take;
    logic [4:0]  w_cause;
    logic        w_mret;
    logic [31:0] w_trap_pc;
    logic        w_unused;

    // HART_ID is reserved and has no visible effect in this revision.
    assign w_unused = ^HART_ID;

`ifdef CSR_VECTORED_EN
    logic [1:0] r_mtvec_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtvec_mode <= (RESET_MTVEC[1:0] == 2'b01) ? 2'b01 : 2'b00;
        end else if (w_wr && csr_addr == A_MTVEC) begin
            r_mtvec_mode <= (w_new[1:0] == 2'b01) ? 2'b01 : 2'b00;
        end
    end

    assign w_mtvec_mode = r_mtvec_mode;
`else
    assign w_mtvec_mode = 2'b00;
`endif

    always_comb begin
        w_old = 32'h0;
        case (csr_addr)
            A_MSTATUS:  w_old = {24'h0, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
            A_MIE:      w_old = {20'h0, r_mie_meie, 3'b000, r_mie_mtie, 7'h00};
            A_MTVEC:    w_old = {r_mtvec_base, w_mtvec_mode};
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = {r_mepc, 2'b00};
            A_MCAUSE:   w_old = r_mcause;
            A_MIP:      w_old = {20'h0, r_mip_meip, 3'b000, r_mip_mtip, 7'h00};
            A_MCYCLE:   w_old = r_mcycle[31:0];
            A_MCYCLEH:  w_old = r_mcycle[63:32];
            default:    w_old = 32'h0;
        endcase
    end

    // funct3[2] selects the zimm form; set/clear with a zero rs1/zimm field is a pure read.
    assign w_src   = funct3[2] ? {27'h0, rs1_zimm} : rs1_data;
    assign w_do_op = (funct3[1:0] != 2'b00) && !(funct3[1] && rs1_zimm == 5'd0);

    always_comb begin
        w_new = w_old;
        case (funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    assign w_ext_pend = r_mie_meie & r_mip_meip;
    assign w_tmr_pend = r_mie_mtie & r_mip_mtip;
    assign w_irq_take = instr_valid && r_mstatus_mie && (w_ext_pend || w_tmr_pend);
    assign w_cause    = w_ext_pend ? 5'd11 : 5'd7;
    assign w_mret     = is_mret && instr_valid && !w_irq_take;
    assign w_wr       = csr_reg_wr && instr_valid && w_do_op && !w_irq_take;
    assign w_trap_pc  = {r_mtvec_base, 2'b00} +
                        ((w_mtvec_mode == 2'b01) ? {25'h0, w_cause, 2'b00} : 32'h0);

    // Outputs are forced quiet while reset is held so a pending redirect is dropped at once.
    always_comb begin
        epc_taken = 1'b0;
        epc       = 32'h0;
        if (!rst) begin
            if (w_irq_take) begin
                epc_taken = 1'b1;
                epc       = w_trap_pc;
            end else if (w_mret) begin
                epc_taken = 1'b1;
                epc       = {r_mepc, 2'b00};
            end
        end
    end

    assign csr_rdata = (!rst && csr_reg_rd && instr_valid) ? w_old : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mtvec_base   <= RESET_MTVEC[31:2];
            r_mscratch     <= 32'h0;
            r_mepc         <= 30'h0;
            r_mcause       <= 32'h0;
            r_mip_mtip     <= 1'b0;
            r_mip_meip     <= 1'b0;
            r_mcycle       <= 64'h0;
        end else begin
            r_mip_mtip <= timer_irq;
            r_mip_meip <= ext_irq;

            if (w_irq_take) begin
                r_mepc         <= pc[31:2];
                r_mcause       <= {1'b1, 26'h0, w_cause};
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (w_wr) begin
                    case (csr_addr)
                        A_MSTATUS: begin
                            r_mstatus_mie  <= w_new[3];
                            r_mstatus_mpie <= w_new[7];
                        end
                        A_MIE: begin
                            r_mie_mtie <= w_new[7];
                            r_mie_meie <= w_new[11];
                        end
                        A_MTVEC:    r_mtvec_base <= w_new[31:2];
                        A_MSCRATCH: r_mscratch   <= w_new;
                        A_MEPC:     r_mepc       <= w_new[31:2];
                        A_MCAUSE:   r_mcause     <= w_new;
                        default:    ;
                    endcase
                end
                if (w_mret) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
            end

            // A write to either half replaces that half and suppresses the count for the cycle.
            if (w_wr && csr_addr == A_MCYCLE) begin
                r_mcycle[31:0] <= w_new;
            end else if (w_wr && csr_addr == A_MCYCLEH) begin
                r_mcycle[63:32] <= w_new;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end
        end
    end

endmodule
